// File: rtl/noc_router_lookup_mc.sv
// Route lookup and multicast fork for one NoC router input port.
// XY unicast routing plus two-phase rectangle broadcast, one-entry output register.
module noc_router_lookup_mc #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned XW         = 2,
  parameter int unsigned YW         = 2,
  parameter int unsigned OUTPUTS    = 5,
  parameter logic [XW-1:0] X        = '0,
  parameter logic [YW-1:0] Y        = '0,
  parameter bit MC_EN               = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_last,
  output logic [OUTPUTS-1:0]    out_valid,
  input  logic [OUTPUTS-1:0]    out_ready
);

  localparam int unsigned IDW     = XW + YW;
  localparam int unsigned NY_LSB  = IDW;
  localparam int unsigned EX_LSB  = IDW + YW;
  localparam int unsigned SY_LSB  = IDW + YW + XW;
  localparam int unsigned WX_LSB  = IDW + 2 * YW + XW;
  localparam int unsigned RW      = 5;
  localparam int unsigned D_LOCAL = 0;
  localparam int unsigned D_NORTH = 1;
  localparam int unsigned D_EAST  = 2;
  localparam int unsigned D_SOUTH = 3;
  localparam int unsigned D_WEST  = 4;

  // Header field views of the incoming flit
  logic [XW-1:0] dx;
  logic [YW-1:0] dy;
  logic [YW-1:0] north_y;
  logic [XW-1:0] east_x;
  logic [YW-1:0] south_y;
  logic [XW-1:0] west_x;
  logic          phase;

  assign dx      = in_flit[0 +: XW];
  assign dy      = in_flit[XW +: YW];
  assign north_y = in_flit[NY_LSB +: YW];
  assign east_x  = in_flit[EX_LSB +: XW];
  assign south_y = in_flit[SY_LSB +: YW];
  assign west_x  = in_flit[WX_LSB +: XW];
  assign phase   = MC_EN & in_flit[FLIT_WIDTH-1];

  logic                  occ;
  logic [OUTPUTS-1:0]    pend;
  logic [OUTPUTS-1:0]    worm;
  logic                  occ_d;
  logic [OUTPUTS-1:0]    pend_d;
  logic [OUTPUTS-1:0]    worm_d;
  logic [FLIT_WIDTH-1:0] flit_d;
  logic                  last_d;
  logic [RW-1:0]         route5;
  logic [OUTPUTS-1:0]    route;
  logic                  centre;
  logic                  idle;
  logic                  load;
  logic [OUTPUTS-1:0]    pend_left;

  // Output set of a header flit at this node
  always_comb begin
    route5 = '0;
    centre = 1'b0;
    if (phase) begin
      route5[D_LOCAL] = 1'b1;
      if (Y != dy) begin
        if ((Y > dy) && (Y < north_y)) route5[D_NORTH] = 1'b1;
        if ((Y < dy) && (Y > south_y)) route5[D_SOUTH] = 1'b1;
      end else begin
        if (Y != north_y)              route5[D_NORTH] = 1'b1;
        if (Y != south_y)              route5[D_SOUTH] = 1'b1;
        if ((X > dx) && (X < east_x))  route5[D_EAST]  = 1'b1;
        if ((X < dx) && (X > west_x))  route5[D_WEST]  = 1'b1;
      end
    end else if (dx > X) begin
      route5[D_EAST] = 1'b1;
    end else if (dx < X) begin
      route5[D_WEST] = 1'b1;
    end else if (dy > Y) begin
      route5[D_NORTH] = 1'b1;
    end else if (dy < Y) begin
      route5[D_SOUTH] = 1'b1;
    end else begin
      centre          = 1'b1;
      route5[D_LOCAL] = 1'b1;
      if (MC_EN) begin
        if (Y != north_y) route5[D_NORTH] = 1'b1;
        if (Y != south_y) route5[D_SOUTH] = 1'b1;
        if (X != east_x)  route5[D_EAST]  = 1'b1;
        if (X != west_x)  route5[D_WEST]  = 1'b1;
      end
    end
  end

  assign route     = OUTPUTS'(route5);
  assign idle      = (worm == '0);
  assign pend_left = pend & ~out_ready;
  assign in_ready  = !occ || (pend_left == '0);
  assign load      = in_valid && in_ready;
  assign out_valid = occ ? pend : '0;

  // Next state: load takes priority, otherwise fork drains the pending mask
  always_comb begin
    occ_d  = occ;
    pend_d = pend;
    worm_d = worm;
    flit_d = out_flit;
    last_d = out_last;
    if (load) begin
      flit_d = in_flit;
      if (idle && centre && MC_EN) flit_d[FLIT_WIDTH-1] = 1'b1;
      last_d = in_last;
      pend_d = idle ? route : worm;
      occ_d  = 1'b1;
      if (in_last) begin
        worm_d = '0;
      end else if (idle) begin
        worm_d = route;
      end
    end else begin
      pend_d = occ ? pend_left : '0;
      if (pend_d == '0) occ_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 1'b0;
      pend     <= '0;
      worm     <= '0;
      out_flit <= '0;
      out_last <= 1'b0;
    end else begin
      occ      <= occ_d;
      pend     <= pend_d;
      worm     <= worm_d;
      out_flit <= flit_d;
      out_last <= last_d;
    end
  end

endmodule

// File: doc/noc_router_lookup_mc.md
# noc_router_lookup_mc

Parametrised route-lookup and fork stage for one router input port of the 2D mesh NoC. It computes the output set of each packet header from the header fields. Unicast uses dimension-order XY routing; multicast uses a two-phase rectangle broadcast. It holds the worm route for body flits and drives one registered flit to up to OUTPUTS output ports with independent per-port ready. This generation replaces the static route table: it adds parametrised mesh coordinate widths, a one-entry output register, and asynchronous multicast fork handling.

## Interface
- FLIT_WIDTH, 32, flit width; must satisfy FLIT_WIDTH-1 >= 3*(XW+YW).
- XW, 2, X coordinate width.
- YW, 2, Y coordinate width.
- OUTPUTS, 5, output count; bit order LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
- X, 0, this node's X coordinate (XW bits).
- Y, 0, this node's Y coordinate (YW bits).
- MC_EN, 1, 1 = multicast fields honoured; 0 = pure XY unicast, flit MSB ignored and never rewritten.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_flit  in  FLIT_WIDTH  input flit.
- in_last  in  1  last flit of packet.
- in_valid  in  1  input valid.
- in_ready  out  1  input ready.
- out_flit  out  FLIT_WIDTH  registered flit, shared by all outputs.
- out_last  out  1  registered last.
- out_valid  out  OUTPUTS  per-output valid (pending mask).
- out_ready  in  OUTPUTS  per-output ready.

## Operation
- Header fields, with IDW = XW+YW:
  - dest {y,x} at [0 +: IDW].
  - north_y at [IDW +: YW], east_x next, south_y next, west_x next.
  - phase bit at FLIT_WIDTH-1.
  - Unicast packets set all four bounds equal to the dest coordinates.
- Route, phase 0 (MSB=0), node != dest: XY routing.
  - EAST if dx>X, else WEST if dx<X.
  - Else NORTH if dy>Y, else SOUTH.
- Route, phase 0, node == dest (centre):
  - LOCAL.
  - NORTH if Y!=north_y; SOUTH if Y!=south_y; EAST if X!=east_x; WEST if X!=west_x.
  - The stored flit has MSB set to 1 (only when MC_EN=1).
- Route, phase 1 (MSB=1):
  - Always LOCAL.
  - If Y!=cy: NORTH if Y>cy and Y<north_y; SOUTH if Y<cy and Y>south_y.
  - If Y==cy: NORTH if Y!=north_y; SOUTH if Y!=south_y; EAST if X>cx and X<east_x; WEST if X<cx and X>west_x.
- All coordinate compares are unsigned, at the XW/YW widths.
- State:
  - occ: register holds a flit.
  - pend[OUTPUTS]: outputs not yet accepted.
  - worm[OUTPUTS]: route of the current packet; 0 means idle, so the next flit is a header.
- Load, when in_valid & in_ready:
  - Store flit (rewritten if needed) and last.
  - pend <= computed route (idle) or worm (in worm).
  - occ <= 1.
  - Header with !in_last: worm <= route.
  - Loaded flit with in_last: worm <= 0.
- Fork: each cycle pend[i] clears when out_valid[i] & out_ready[i]. out_valid = pend when occ, else 0.
- Drain: occ clears when pend reaches 0 with no simultaneous load.
- in_ready = !occ | ((pend & ~out_ready) == 0), combinational from state and out_ready.

## Timing
- Reset values: out_valid=0, out_flit=0, out_last=0, occ=0, pend=0, worm=0. in_ready=1 while in reset and after it.
- Latency: a flit accepted at edge t appears on out_* in cycle t+1.
- Throughput: 1 flit/cycle while all pending outputs are ready.
- Final acceptance and new load in the same cycle: the register reloads with no bubble.
- Partial multicast acceptance: only the non-accepting outputs keep out_valid high; out_flit is stable until every output has accepted.
- Single-flit packet: worm stays 0; the next flit is a header.
- A zero in_valid cycle inside a worm keeps worm unchanged.
- Reset mid-packet: the register and worm clear immediately. The next valid flit is treated as a header.

## Test plan
- X=1,Y=1. Unicast dest (y1,x3), bounds (1,3,1,3), 3 flits, out_ready=11111 → out_valid=00100 for cycles t+1..t+3. out_last high on 3rd. Flits unmodified.
- Centre multicast: dest (1,1), N=3, E=2, S=0, W=1, MSB=0 → out_valid=01111, out_flit MSB=1, other bits unchanged.
- Fork backpressure, same header: out_ready=00001, then 01110 → out_valid 01111 → 01110 → 00000. in_ready=0 in the first cycle, 1 in the second.
- Phase 1 at (1,1): cy=0, cx=1, north_y=3 → out_valid=00011. Same header at Y=3 → out_valid=00001.
- Back-to-back single-flit headers routed EAST then WEST, all ready → out_valid 00100 then 10000 on consecutive cycles. in_ready held 1.
- Reset asserted after the header of a 4-flit worm → out_valid=0 during reset. The next valid flit after release is routed as a header.
